// File: rtl/interfaz_adc_spi.sv
`default_nettype none
// ============================================================================
// Module      : interfaz_adc_spi
// Description : Capture stage for a 12-bit serial ADC (16-clock SPI frame,
//               4 leading zeros, MSB first). A sample-rate timer paces the
//               conversions. Each result is converted from offset binary to a
//               signed N-bit fixed-point word with D fractional bits.
//               Every new word is announced with a one-cycle strobe.
// Ports       : Clk, Reset (async, active high)  - clock and reset
//               Habilitar                        - enables the sample timer
//               SDATA                            - ADC serial data in
//               CS_n, SCLK                       - ADC chip select / clock
//               Uk [N-1:0]                       - latest converted sample
//               Bandera_ADC                      - new-sample strobe
//               Ocupado                          - frame in progress
//               Solape                           - sample tick dropped
// Revision    : 1.0 - initial release
// ============================================================================
module interfaz_adc_spi #(
  parameter int N               = 25,
  parameter int D               = 15,
  parameter int DIV_SCLK        = 4,
  parameter int PERIODO_MUESTRA = 10000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Habilitar,
  input  logic         SDATA,
  output logic         CS_n,
  output logic         SCLK,
  output logic [N-1:0] Uk,
  output logic         Bandera_ADC,
  output logic         Ocupado,
  output logic         Solape
);

  localparam int CW = $clog2(PERIODO_MUESTRA);
  localparam int DW = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
  localparam logic [CW-1:0] c_cuenta_ult = CW'(PERIODO_MUESTRA - 1);
  localparam logic [DW-1:0] c_div_ult    = DW'(DIV_SCLK - 1);
  localparam logic [3:0]    c_bit_ult    = 4'd15;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    TRAMA   = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  // --------------------------------------------------------------------------
  // Sample-rate timer. The tick is registered, so it is seen exactly
  // PERIODO_MUESTRA cycles after Habilitar rises and then every period.
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_cuenta;
  logic          r_tick;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cuenta <= '0;
      r_tick   <= 1'b0;
    end else if (!Habilitar) begin
      r_cuenta <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick   <= (r_cuenta == c_cuenta_ult);
      r_cuenta <= (r_cuenta == c_cuenta_ult) ? '0 : r_cuenta + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM and registered outputs
  // --------------------------------------------------------------------------
  estado_t       r_estado, w_estado;
  logic [DW-1:0] r_div, w_div;
  logic [3:0]    r_bit, w_bit;
  // Only the last 12 shifted bits are kept: the four leading bits fall off
  // the top of the register and are never looked at.
  logic [11:0]   r_desp, w_desp;
  logic          w_cs_n, w_sclk, w_bandera, w_ocupado, w_solape;
  logic [N-1:0]  w_uk;

  // Offset binary to two's complement is just an MSB inversion.
  logic signed [11:0] w_muestra;
  logic        [N-1:0] w_ext;
  logic        [N-1:0] w_conv;

  assign w_muestra = {~r_desp[11], r_desp[10:0]};
  assign w_ext     = {{(N-12){w_muestra[11]}}, w_muestra};
  assign w_conv    = w_ext << (D - 11);

  always_comb begin
    w_estado  = r_estado;
    w_div     = r_div;
    w_bit     = r_bit;
    w_desp    = r_desp;
    w_cs_n    = CS_n;
    w_sclk    = SCLK;
    w_uk      = Uk;
    w_bandera = 1'b0;
    w_ocupado = Ocupado;
    w_solape  = r_tick && (r_estado != REPOSO);

    case (r_estado)
      REPOSO: begin
        if (r_tick) begin
          w_estado  = TRAMA;
          w_cs_n    = 1'b0;
          w_sclk    = 1'b0;
          w_ocupado = 1'b1;
          w_div     = '0;
          w_bit     = '0;
        end
      end

      TRAMA: begin
        if (r_div == c_div_ult) begin
          w_div = '0;
          if (!SCLK) begin
            // Same edge that raises SCLK captures the data bit, which the ADC
            // has held stable since the previous falling edge.
            w_sclk = 1'b1;
            w_desp = {r_desp[10:0], SDATA};
          end else if (r_bit == c_bit_ult) begin
            // Last high phase done: SCLK stays high (its idle level).
            w_estado  = ENTREGA;
            w_cs_n    = 1'b1;
            w_ocupado = 1'b0;
            w_bandera = 1'b1;
            w_uk      = w_conv;
          end else begin
            w_sclk = 1'b0;
            w_bit  = r_bit + 4'd1;
          end
        end else begin
          w_div = r_div + DW'(1);
        end
      end

      ENTREGA: begin
        w_estado = REPOSO;
      end

      default: begin
        w_estado = REPOSO;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_estado    <= REPOSO;
      r_div       <= '0;
      r_bit       <= '0;
      r_desp      <= '0;
      CS_n        <= 1'b1;
      SCLK        <= 1'b1;
      Uk          <= '0;
      Bandera_ADC <= 1'b0;
      Ocupado     <= 1'b0;
      Solape      <= 1'b0;
    end else begin
      r_estado    <= w_estado;
      r_div       <= w_div;
      r_bit       <= w_bit;
      r_desp      <= w_desp;
      CS_n        <= w_cs_n;
      SCLK        <= w_sclk;
      Uk          <= w_uk;
      Bandera_ADC <= w_bandera;
      Ocupado     <= w_ocupado;
      Solape      <= w_solape;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interfaz_adc_spi.sv
`default_nettype none
// ============================================================================
// Module      : tb_interfaz_adc_spi
// Description : Self-checking bench for interfaz_adc_spi. Two instances:
//               A runs at a legal sample rate, B at a rate too fast for the
//               frame so that ticks overlap. Behavioural ADC models serve
//               random or scripted 16-bit frames. Expected samples come from
//               the offset-binary rule applied with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interfaz_adc_spi;

  localparam int N     = 25;
  localparam int D     = 15;
  localparam int DIV   = 4;
  localparam int PER_A = 200;
  localparam int PER_B = 100;
  localparam int LAT   = 32 * DIV + 1;   // tick to strobe, in cycles

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         hab_a = 1'b0, sdata_a = 1'b0;
  logic         cs_a, sclk_a, band_a, ocu_a, sol_a;
  logic [N-1:0] uk_a;
  logic         hab_b = 1'b0, sdata_b = 1'b0;
  logic         cs_b, sclk_b, band_b, ocu_b, sol_b;
  logic [N-1:0] uk_b;

  always #5 clk = ~clk;

  interfaz_adc_spi #(.N(N), .D(D), .DIV_SCLK(DIV), .PERIODO_MUESTRA(PER_A)) dut_a (
    .Clk(clk), .Reset(rst), .Habilitar(hab_a), .SDATA(sdata_a),
    .CS_n(cs_a), .SCLK(sclk_a), .Uk(uk_a), .Bandera_ADC(band_a),
    .Ocupado(ocu_a), .Solape(sol_a)
  );

  interfaz_adc_spi #(.N(N), .D(D), .DIV_SCLK(DIV), .PERIODO_MUESTRA(PER_B)) dut_b (
    .Clk(clk), .Reset(rst), .Habilitar(hab_b), .SDATA(sdata_b),
    .CS_n(cs_b), .SCLK(sclk_b), .Uk(uk_b), .Bandera_ADC(band_b),
    .Ocupado(ocu_b), .Solape(sol_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Fixed-point value of an ADC frame: (12-bit code - 2048) * 2^(D-11).
  function automatic int uk_ref(input logic [15:0] w);
    return (int'(w[11:0]) - 2048) * (1 << (D - 11));
  endfunction

  initial forever @(posedge clk) cyc = cyc + 1;

  // --------------------------------------------------------------------------
  // Instance A: ADC model + monitor
  // --------------------------------------------------------------------------
  logic [15:0] forced_a[$];
  int          exp_a[$];
  logic [15:0] word_a = '0;
  int          k_a = 0, rises_a = 0, strobes_a = 0, csfall_a = 0;
  int          last_fall_a = 0, last_strobe_a = 0;
  logic        pcs_a = 1'b1, psclk_a = 1'b1, pband_a = 1'b0;

  initial forever @(negedge clk) begin
    if (pcs_a && !cs_a) begin
      word_a = (forced_a.size() > 0) ? forced_a.pop_front() : 16'($urandom);
      exp_a.push_back(uk_ref(word_a));
      k_a = 0;
      rises_a = 0;
      csfall_a++;
      last_fall_a = cyc;
      sdata_a = word_a[15];
      chk("a_frame_start_sclk", sclk_a, 0);
      chk("a_frame_start_ocupado", ocu_a, 1);
    end else if (!cs_a && psclk_a && !sclk_a && k_a < 15) begin
      k_a++;
      sdata_a = word_a[15 - k_a];
    end
    if (!cs_a && !psclk_a && sclk_a) rises_a++;
    if (band_a) begin
      strobes_a++;
      last_strobe_a = cyc;
      chk("a_strobe_width", pband_a, 0);
      chk("a_strobe_cs_n", cs_a, 1);
      chk("a_strobe_ocupado", ocu_a, 0);
      chk("a_sclk_rises", rises_a, 16);
      chk("a_pending_frames", exp_a.size(), 1);
      if (exp_a.size() > 0) chk("a_uk", $signed(uk_a), exp_a.pop_front());
    end
    pcs_a = cs_a;
    psclk_a = sclk_a;
    pband_a = band_a;
  end

  // --------------------------------------------------------------------------
  // Instance B: ADC model + monitor (overrun scenario)
  // --------------------------------------------------------------------------
  int          exp_b[$];
  logic [15:0] word_b = '0;
  int          k_b = 0, strobes_b = 0, solapes_b = 0, c0b = 0;
  logic        pcs_b = 1'b1, psclk_b = 1'b1;

  initial forever @(negedge clk) begin
    if (pcs_b && !cs_b) begin
      word_b = 16'($urandom);
      exp_b.push_back(uk_ref(word_b));
      k_b = 0;
      sdata_b = word_b[15];
    end else if (!cs_b && psclk_b && !sclk_b && k_b < 15) begin
      k_b++;
      sdata_b = word_b[15 - k_b];
    end
    if (band_b) begin
      strobes_b++;
      chk("b_pending_frames", exp_b.size(), 1);
      if (exp_b.size() > 0) chk("b_uk", $signed(uk_b), exp_b.pop_front());
    end
    if (sol_b) begin
      solapes_b++;
      chk("b_solape_phase", (cyc - c0b - 1) % PER_B, 0);
      chk("b_solape_busy", ocu_b, 1);
    end
    pcs_b = cs_b;
    psclk_b = sclk_b;
  end

  // --------------------------------------------------------------------------
  // Bounded waits
  // --------------------------------------------------------------------------
  task automatic wait_strobe_a(input int budget, input string tag);
    int n0 = strobes_a;
    int i = 0;
    while (strobes_a == n0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, strobes_a != n0, 1);
  endtask

  task automatic wait_fall_a(input int budget, input string tag);
    int n0 = csfall_a;
    int i = 0;
    while (csfall_a == n0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, csfall_a != n0, 1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int c0, s_prev, n_save, busy_end, exp_str, exp_sol;
  int scripted_uk[5] = '{0, 32752, -32768, 16, -28112};
  logic [15:0] scripted[5] = '{16'h0800, 16'h0FFF, 16'h0000, 16'h0801, 16'hF123};

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", cs_a, 1);
    chk("rst_sclk", sclk_a, 1);
    chk("rst_uk", $signed(uk_a), 0);
    chk("rst_bandera", band_a, 0);
    chk("rst_ocupado", ocu_a, 0);
    chk("rst_solape", sol_a, 0);

    // Disabled timer: no frame may start.
    repeat (20000) @(negedge clk);
    chk("idle_cs_falls", csfall_a, 0);
    chk("idle_strobes", strobes_a, 0);

    // Scripted frames: mid-scale, extremes, leading-bit tolerance.
    foreach (scripted[i]) forced_a.push_back(scripted[i]);
    c0 = cyc;
    hab_a = 1'b1;
    wait_strobe_a(PER_A + LAT + 20, "first_strobe_timeout");
    chk("first_cs_fall_latency", last_fall_a - c0, PER_A + 1);
    chk("first_strobe_latency", last_strobe_a - c0, PER_A + LAT);
    chk("uk_scripted_0", $signed(uk_a), scripted_uk[0]);
    for (int i = 1; i < 5; i++) begin
      s_prev = last_strobe_a;
      wait_strobe_a(PER_A + 20, "scripted_strobe_timeout");
      chk("strobe_spacing", last_strobe_a - s_prev, PER_A);
      chk("uk_scripted", $signed(uk_a), scripted_uk[i]);
    end

    // Random frames, checked by the monitor against the model.
    repeat (8) wait_strobe_a(PER_A + 20, "random_strobe_timeout");

    // Drop Habilitar around bit 8: frame completes, nothing follows.
    wait_fall_a(PER_A + 20, "drop_frame_start_timeout");
    repeat (16 * DIV) @(negedge clk);
    hab_a = 1'b0;
    wait_strobe_a(LAT, "drop_frame_strobe_timeout");
    n_save = csfall_a;
    repeat (3 * PER_A) @(negedge clk);
    chk("no_frame_after_disable", csfall_a, n_save);

    // Reset around bit 8: no strobe, outputs back to idle at once.
    hab_a = 1'b1;
    wait_fall_a(PER_A + 20, "abort_frame_start_timeout");
    repeat (16 * DIV) @(negedge clk);
    n_save = strobes_a;
    rst = 1'b1;
    hab_a = 1'b0;
    #1;
    chk("abort_cs_n", cs_a, 1);
    chk("abort_sclk", sclk_a, 1);
    chk("abort_ocupado", ocu_a, 0);
    chk("abort_uk", $signed(uk_a), 0);
    exp_a.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 50) @(negedge clk);
    chk("abort_no_strobe", strobes_a, n_save);
    c0 = cyc;
    hab_a = 1'b1;
    wait_strobe_a(PER_A + LAT + 20, "post_abort_strobe_timeout");
    chk("post_abort_latency", last_strobe_a - c0, PER_A + LAT);
    hab_a = 1'b0;
    repeat (20) @(negedge clk);

    // Overrun on instance B: period shorter than one frame.
    c0b = cyc;
    hab_b = 1'b1;
    repeat (1050) @(negedge clk);
    hab_b = 1'b0;
    repeat (300) @(negedge clk);
    busy_end = -1;
    exp_str = 0;
    exp_sol = 0;
    for (int t = PER_B; t < 1050; t += PER_B) begin
      if (t <= busy_end) exp_sol++;
      else begin
        exp_str++;
        busy_end = t + LAT;
      end
    end
    chk("overrun_strobes", strobes_b, exp_str);
    chk("overrun_solapes", solapes_b, exp_sol);
    chk("overrun_queue_empty", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
